// File: rtl/spi_cmd_controller.sv
// spi_cmd_controller
//   Command-frame controller between the board SPI pins (mode 0, MSB first)
//   and the PWM / BCD datapath. SCK, CS and MOSI are resynchronised into the
//   SLK domain. Bytes are assembled on SCK rising edges. A two-byte frame
//   {opcode, data} writes the PWM duty or the BCD digit register. A status
//   opcode returns {duty, digit} on MISO during the second byte.
//
// Ports
//   SLK        in   system clock, rising edge
//   RST        in   asynchronous reset, active-high
//   SCK        in   SPI serial clock (asynchronous, mode 0)
//   CS         in   SPI chip select, active-low (asynchronous)
//   MOSI       in   SPI data in, MSB first
//   MISO       out  SPI data out, MSB first (status reads only, else 0)
//   duty       out  PWM duty setting
//   digit      out  BCD display value
//   cfg_strobe out  one-cycle pulse when duty or digit is written
//   frame_err  out  one-cycle pulse on a protocol error
module spi_cmd_controller #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] OP_DUTY     = 8'hA1,
  parameter logic [7:0] OP_DIGIT    = 8'hA2,
  parameter logic [7:0] OP_STATUS   = 8'hA3
) (
  input  logic       SLK,
  input  logic       RST,
  input  logic       SCK,
  input  logic       CS,
  input  logic       MOSI,
  output logic       MISO,
  output logic [3:0] duty,
  output logic [3:0] digit,
  output logic       cfg_strobe,
  output logic       frame_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_prev;
  logic                   cs_prev;

  logic sck_s;
  logic cs_s;
  logic mosi_s;
  logic sck_rise;
  logic sck_fall;
  logic cs_rise;
  logic cs_fall;

  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       byte_done;
  logic [7:0] rx_byte;

  logic [2:0] state;
  logic [7:0] op;
  logic       rd_mode;
  logic [7:0] tx;

  function automatic logic is_write_op(input logic [7:0] b);
    return (b == OP_DUTY) || (b == OP_DIGIT);
  endfunction

  // Synchroniser stage: CS resets to its idle (high) level so that releasing
  // reset with the bus idle does not look like a frame start.
  always_ff @(posedge SLK or posedge RST) begin
    if (RST) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sck_prev  <= sck_s;
      cs_prev   <= cs_s;
    end
  end

  always_comb begin
    sck_s    = sck_sync[SYNC_STAGES-1];
    cs_s     = cs_sync[SYNC_STAGES-1];
    mosi_s   = mosi_sync[SYNC_STAGES-1];
    sck_rise = sck_s & ~sck_prev & ~cs_s;
    sck_fall = ~sck_s & sck_prev & ~cs_s;
    cs_rise  = cs_s & ~cs_prev;
    cs_fall  = ~cs_s & cs_prev;
    // SCK edges are gated by synced CS low, so a byte completing in the same
    // cycle CS rises never produces byte_done: CS wins.
    rx_byte   = {shift[6:0], mosi_s};
    byte_done = sck_rise && (bit_cnt == 3'd7);
  end

  // Bit assembly stage
  always_ff @(posedge SLK or posedge RST) begin
    if (RST) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (cs_s) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (sck_rise) begin
      shift   <= rx_byte;
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Frame FSM / register stage
  always_ff @(posedge SLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      op         <= '0;
      rd_mode    <= 1'b0;
      tx         <= '0;
      duty       <= '0;
      digit      <= '0;
      cfg_strobe <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cfg_strobe <= 1'b0;
      frame_err  <= 1'b0;
      if (cs_rise) begin
        // A frame ends early if an opcode was partially clocked or the data
        // byte never completed; CS toggled with no clocks is silent.
        if ((state == S_DATA) || ((state == S_CMD) && (bit_cnt != 3'd0)))
          frame_err <= 1'b1;
        state   <= S_IDLE;
        rd_mode <= 1'b0;
        tx      <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cs_fall) begin
              state   <= S_CMD;
              rd_mode <= 1'b0;
            end
          end
          S_CMD: begin
            if (byte_done) begin
              op <= rx_byte;
              if (is_write_op(rx_byte)) begin
                state <= S_DATA;
              end else if (rx_byte == OP_STATUS) begin
                state   <= S_DATA;
                rd_mode <= 1'b1;
                tx      <= {duty, digit};
              end else begin
                state     <= S_ERR;
                frame_err <= 1'b1;
              end
            end
          end
          S_DATA: begin
            if (byte_done) begin
              if (is_write_op(op)) begin
                if (rx_byte[7:4] == 4'd0) begin
                  if (op == OP_DUTY) duty <= rx_byte[3:0];
                  else               digit <= rx_byte[3:0];
                  cfg_strobe <= 1'b1;
                  state      <= S_DONE;
                end else begin
                  frame_err <= 1'b1;
                  state     <= S_ERR;
                end
              end else begin
                state <= S_DONE;
              end
            end else if (rd_mode && sck_fall && (bit_cnt != 3'd0)) begin
              // The falling edge right after the opcode's last rise has
              // bit_cnt == 0; skipping it keeps tx[7] on MISO for the first
              // rise of the data byte.
              tx <= {tx[6:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign MISO = (state == S_DATA) && rd_mode && tx[7];

endmodule
